fp_sub_pipe: RTL and testbench
==============================

Name: fp_sub_pipe

Overview:
- Pipelined bfloat16 subtractor: computes diff = opA - opB over 3 stages with valid/ready handshake on input and output.
- Serves as the counterpart to the PE's combinational bf16 adder, supplying the negative-delta path (residual/delta retraction) in the GraphPulse PE datapath.
- Uses the same number format as the adder: 1 sign, 8 exponent, 7 mantissa bits, implicit leading 1, truncation, no NaN/denormal support.
- Uses the same flag set as the adder.

Parameters:
- EXP_W, 8, exponent width; only 8 is verified.
- MAN_W, 7, stored mantissa width; only 7 is verified.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- opA  in  16  minuend, bf16
- opB  in  16  subtrahend, bf16
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  16  bf16 result
- underflow  out  1  result exponent underflowed; result flushed to zero
- overflow  out  1  result exponent reached 255; result is ±inf
- inexact  out  1  nonzero bits were discarded during alignment or normalization
- cout  out  1  mantissa magnitude add carried out (effective-add case only)

Behaviour:
- Reset (async, reset_n=0): all stage valid bits = 0; out_valid = 0; diff = 16'h0000; all flags = 0. A reset mid-operation discards in-flight data. in_ready = 1 immediately after reset.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational). All three stages shift only when adv = 1, so a stall freezes the whole pipe.
- Accept: transfer when in_valid & in_ready. Latency is exactly 3 cycles with no stall: an op accepted at edge N appears with out_valid = 1 after edge N+3. Throughput is 1 per cycle.
- Bubbles propagate as valid = 0. Order is preserved and no result is dropped or duplicated.
- Output hold: while out_valid & !out_ready, diff and the flags stay stable.
- S1, align:
  - Flip sB to get the effective sign.
  - sub_eff = sA ^ sB'.
  - Compare exponents; big operand = larger exponent, or larger mantissa when exponents are equal.
  - Shift the small operand's {1,mant} (8 bits) right by |eA-eB|. A shift of 8 or more gives 0.
  - sticky1 = OR of the bits shifted out. No guard bits are kept.
  - Register: sign of big operand, bigE, op_big, op_small, sub_eff, sticky1, exact_cancel (opA[14:0]==opB[14:0] & sub_eff).
- S2, mantissa:
  - If sub_eff: m = op_big - op_small. This is never negative because of the S1 ordering.
  - Else: {c,m} = op_big + op_small (9 bits).
  - Register m, c, and the S1 fields.
- S3, normalize and pack:
  - Add case: if c, shift right by 1, E = bigE+1, and sticky2 = m[0]. cout = c.
  - Sub case: lz = leading zeros of m (0..7); shift left by lz; E = bigE - lz computed signed, 10 bits wide. cout = 0.
  - exact_cancel → diff = 16'h0000, all flags 0 (+0 always).
  - E ≤ 0 → diff = 16'h0000, underflow = 1.
  - E ≥ 255 → diff = {sign, 8'hFF, 7'h0}, overflow = 1.
  - Otherwise diff = {sign, E[7:0], mant[6:0]}.
  - inexact = sticky1 | sticky2.
- Input exponent 0 is treated as a normal value with an implicit 1; no special case.

Test Plan:
- 0x4040 - 0x3F80 (3-1), out_ready=1 → diff=0x4000 exactly 3 cycles after accept, all flags 0.
- 0x3F80 - 0x3F80 → 0x0000, flags 0. 0x3F80 - 0xBF80 → 0x4000, cout=1. 0x3F80 - 0x4000 → 0xBF80.
- 0x3F80 - 0x3B00 (1 - 2^-9) → 0x3F80, inexact=1. 0x00C0 - 0x0080 → 0x0000, underflow=1. 0x7F00 - 0xFF00 → 0x7F80, overflow=1.
- Stall: 3 back-to-back ops (0x4040-0x3F80, 0x4000-0x3F00, 0x3F80-0x4000), out_ready held low 4 cycles after the first output → in_ready=0 during the stall, diff held at 0x4000. On release, 0x4000, 0x3FC0, 0xBF80 emerge in order on consecutive cycles.
- Random bursts with in_valid and out_ready each toggled at 50% → scoreboard against a reference model: no loss or duplication, order preserved.
- Reset: assert reset_n=0 with 2 ops in flight → out_valid=0 and diff=0 asynchronously. After release, in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/fp_sub_pipe.sv
// Pipelined bfloat16 subtractor: diff = opA - opB, truncating, no NaN/denormal handling.
// Operand capture, align, mantissa and normalize/pack ranks share one stall enable.
module fp_sub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] opA,
  input  logic [EXP_W+MAN_W:0] opB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] diff,
  output logic                 underflow,
  output logic                 overflow,
  output logic                 inexact,
  output logic                 cout
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned M    = MAN_W + 1;
  localparam int unsigned LZ_W = $clog2(M);
  localparam int unsigned EE_W = EXP_W + 2;

  logic adv;

  // capture rank
  logic         v0_q, v0_d;
  logic [W-1:0] a0_q, a0_d, b0_q, b0_d;

  // align rank
  logic             v1_q, v1_d, sign1_q, sign1_d, sub1_q, sub1_d;
  logic             stk1_q, stk1_d, canc1_q, canc1_d;
  logic [EXP_W-1:0] e1_q, e1_d;
  logic [M-1:0]     big1_q, big1_d, sml1_q, sml1_d;

  // mantissa rank
  logic             v2_q, v2_d, sign2_q, sign2_d, sub2_q, sub2_d;
  logic             stk2_q, stk2_d, canc2_q, canc2_d, c2_q, c2_d;
  logic [EXP_W-1:0] e2_q, e2_d;
  logic [M-1:0]     m2_q, m2_d;

  // output rank
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] diff_q, diff_d;
  logic         uf_q, uf_d, of_q, of_d, inx_q, inx_d, cout_q, cout_d;

  // align intermediates
  logic             sa, sb, a_big;
  logic [EXP_W-1:0] ea, eb, ediff;
  logic [M-1:0]     ma, mb, small_m, lost_mask;

  // mantissa / normalize intermediates
  logic [M:0]       sum2;
  logic [LZ_W-1:0]  lz;
  logic [EE_W-1:0]  e_n;
  logic [MAN_W-1:0] mant;
  logic             stk_norm;

  assign adv       = !out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign underflow = uf_q;
  assign overflow  = of_q;
  assign inexact   = inx_q;
  assign cout      = cout_q;

  always_comb begin
    v0_d = v0_q;
    a0_d = a0_q;
    b0_d = b0_q;
    if (adv) begin
      v0_d = in_valid;
      a0_d = opA;
      b0_d = opB;
    end
  end

  // Subtrahend sign is flipped up front so the rest is a signed-magnitude add.
  always_comb begin
    sa        = a0_q[W-1];
    sb        = ~b0_q[W-1];
    ea        = a0_q[W-2:MAN_W];
    eb        = b0_q[W-2:MAN_W];
    ma        = {1'b1, a0_q[MAN_W-1:0]};
    mb        = {1'b1, b0_q[MAN_W-1:0]};
    a_big     = (ea > eb) || ((ea == eb) && (ma >= mb));
    ediff     = a_big ? (ea - eb) : (eb - ea);
    small_m   = a_big ? mb : ma;
    lost_mask = ~({M{1'b1}} << ediff);

    v1_d    = v1_q;
    sign1_d = sign1_q;
    sub1_d  = sub1_q;
    stk1_d  = stk1_q;
    canc1_d = canc1_q;
    e1_d    = e1_q;
    big1_d  = big1_q;
    sml1_d  = sml1_q;
    if (adv) begin
      v1_d    = v0_q;
      sign1_d = a_big ? sa : sb;
      sub1_d  = sa ^ sb;
      stk1_d  = |(small_m & lost_mask);
      canc1_d = (a0_q[W-2:0] == b0_q[W-2:0]) & (sa ^ sb);
      e1_d    = a_big ? ea : eb;
      big1_d  = a_big ? ma : mb;
      sml1_d  = small_m >> ediff;
    end
  end

  always_comb begin
    sum2 = sub1_q ? {1'b0, big1_q - sml1_q}
                  : ({1'b0, big1_q} + {1'b0, sml1_q});

    v2_d    = v2_q;
    sign2_d = sign2_q;
    sub2_d  = sub2_q;
    stk2_d  = stk2_q;
    canc2_d = canc2_q;
    c2_d    = c2_q;
    e2_d    = e2_q;
    m2_d    = m2_q;
    if (adv) begin
      v2_d    = v1_q;
      sign2_d = sign1_q;
      sub2_d  = sub1_q;
      stk2_d  = stk1_q;
      canc2_d = canc1_q;
      c2_d    = sum2[M];
      e2_d    = e1_q;
      m2_d    = sum2[M-1:0];
    end
  end

  // Exponent is carried two bits wider so a borrow below zero shows in the top bit.
  always_comb begin
    lz = LZ_W'(M - 1);
    for (int unsigned i = 0; i < M; i++) begin
      if (m2_q[i]) lz = LZ_W'(M - 1 - i);
    end

    stk_norm = 1'b0;
    if (sub2_q) begin
      e_n  = {2'b00, e2_q} - {{(EE_W-LZ_W){1'b0}}, lz};
      mant = MAN_W'(m2_q << lz);
    end else if (c2_q) begin
      e_n      = {2'b00, e2_q} + EE_W'(1);
      mant     = m2_q[M-1:1];
      stk_norm = m2_q[0];
    end else begin
      e_n  = {2'b00, e2_q};
      mant = m2_q[MAN_W-1:0];
    end

    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    uf_d        = uf_q;
    of_d        = of_q;
    inx_d       = inx_q;
    cout_d      = cout_q;
    if (adv) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        uf_d   = 1'b0;
        of_d   = 1'b0;
        inx_d  = stk2_q | stk_norm;
        cout_d = c2_q & ~sub2_q;
        if (canc2_q) begin
          diff_d = '0;
          inx_d  = 1'b0;
          cout_d = 1'b0;
        end else if (e_n[EE_W-1] || (e_n == '0)) begin
          diff_d = '0;
          uf_d   = 1'b1;
        end else if (e_n[EE_W-2:0] >= {1'b0, {EXP_W{1'b1}}}) begin
          diff_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          of_d   = 1'b1;
        end else begin
          diff_d = {sign2_q, e_n[EXP_W-1:0], mant};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v0_q        <= 1'b0;
      a0_q        <= '0;
      b0_q        <= '0;
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      sub1_q      <= 1'b0;
      stk1_q      <= 1'b0;
      canc1_q     <= 1'b0;
      e1_q        <= '0;
      big1_q      <= '0;
      sml1_q      <= '0;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      sub2_q      <= 1'b0;
      stk2_q      <= 1'b0;
      canc2_q     <= 1'b0;
      c2_q        <= 1'b0;
      e2_q        <= '0;
      m2_q        <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
      inx_q       <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      a0_q        <= a0_d;
      b0_q        <= b0_d;
      v1_q        <= v1_d;
      sign1_q     <= sign1_d;
      sub1_q      <= sub1_d;
      stk1_q      <= stk1_d;
      canc1_q     <= canc1_d;
      e1_q        <= e1_d;
      big1_q      <= big1_d;
      sml1_q      <= sml1_d;
      v2_q        <= v2_d;
      sign2_q     <= sign2_d;
      sub2_q      <= sub2_d;
      stk2_q      <= stk2_d;
      canc2_q     <= canc2_d;
      c2_q        <= c2_d;
      e2_q        <= e2_d;
      m2_q        <= m2_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
      inx_q       <= inx_d;
      cout_q      <= cout_d;
    end
  end

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Directed-vector bench for fp_sub_pipe: table vectors, stall, random handshake bursts, reset.
module tb_fp_sub_pipe;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] opA, opB, diff;
  logic        underflow, overflow, inexact, cout;

  int total = 0;
  int bad   = 0;

  // flags packed as {underflow, overflow, inexact, cout}
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [3:0]  f;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  always #5 clock = ~clock;

  fp_sub_pipe #(.EXP_W(8), .MAN_W(7)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .underflow (underflow),
    .overflow  (overflow),
    .inexact   (inexact),
    .cout      (cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k);
    int n;
    @(negedge clock);
    check($sformatf("in_ready_v%0d", k), 32'(in_ready), 1);
    opA = tbl[k].a;
    opB = tbl[k].b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("latency_v%0d", k), n, 3);
    check($sformatf("diff_v%0d", k), 32'(diff), 32'(tbl[k].d));
    check($sformatf("flags_v%0d", k), 32'({underflow, overflow, inexact, cout}), 32'(tbl[k].f));
  endtask

  initial begin
    int n;
    int q[$];
    int sent, got, idx, e;
    logic held;
    logic [19:0] held_v;
    logic stale;

    tbl[0]  = '{16'h4040, 16'h3F80, 16'h4000, 4'b0000};
    tbl[1]  = '{16'h3F80, 16'h3F80, 16'h0000, 4'b0000};
    tbl[2]  = '{16'h3F80, 16'hBF80, 16'h4000, 4'b0001};
    tbl[3]  = '{16'h3F80, 16'h4000, 16'hBF80, 4'b0000};
    tbl[4]  = '{16'h3F80, 16'h3B00, 16'h3F80, 4'b0010};
    tbl[5]  = '{16'h00C0, 16'h0080, 16'h0000, 4'b1000};
    tbl[6]  = '{16'h7F00, 16'hFF00, 16'h7F80, 4'b0101};
    tbl[7]  = '{16'h4000, 16'h3F00, 16'h3FC0, 4'b0000};
    tbl[8]  = '{16'h3FC0, 16'hBF80, 16'h4020, 4'b0001};
    tbl[9]  = '{16'hC000, 16'hC040, 16'h3F80, 4'b0000};
    tbl[10] = '{16'h4000, 16'hBF81, 16'h4040, 4'b0010};
    tbl[11] = '{16'h3F81, 16'h3F80, 16'h3C00, 4'b0000};
    tbl[12] = '{16'hBF80, 16'hBF80, 16'h0000, 4'b0000};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opA       = '0;
    opB       = '0;
    repeat (2) @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_flags", 32'({underflow, overflow, inexact, cout}), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 1);

    for (int k = 0; k < NV; k++) run_vec(k);

    // stall: three back-to-back ops, consumer blocks for four cycles
    @(negedge clock);
    opA = 16'h4040; opB = 16'h3F80; in_valid = 1'b1;
    @(negedge clock);
    opA = 16'h4000; opB = 16'h3F00;
    @(negedge clock);
    opA = 16'h3F80; opB = 16'h4000;
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("stall_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("stall_diff_%0d", i), 32'(diff), 32'h4000);
      check($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 1);
    @(negedge clock);
    check("release_valid_1", 32'(out_valid), 1);
    check("release_diff_1", 32'(diff), 32'h3FC0);
    @(negedge clock);
    check("release_valid_2", 32'(out_valid), 1);
    check("release_diff_2", 32'(diff), 32'hBF80);
    @(negedge clock);
    check("release_drained", 32'(out_valid), 0);

    // random handshake bursts, expected results taken from the vector table
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_v = '0;
    idx = 0;
    for (int cyc = 0; cyc < 3000 && (sent < 40 || q.size() > 0); cyc++) begin
      @(negedge clock);
      if (held) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_value", 32'({diff, underflow, overflow, inexact, cout}), 32'(held_v));
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 40) begin
        in_valid = 1'($urandom_range(0, 1));
        idx = $urandom_range(0, NV - 1);
        opA = tbl[idx].a;
        opB = tbl[idx].b;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("burst_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) begin
        q.push_back(idx);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("burst_spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("burst_diff_%0d", got), 32'(diff), 32'(tbl[e].d));
          check($sformatf("burst_flags_%0d", got),
                32'({underflow, overflow, inexact, cout}), 32'(tbl[e].f));
          got++;
        end
      end
      held   = out_valid && !out_ready;
      held_v = {diff, underflow, overflow, inexact, cout};
    end
    check("burst_sent", sent, 40);
    check("burst_got", got, 40);
    check("burst_left", q.size(), 0);

    // reset with operations in flight
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    opA = 16'h4040; opB = 16'h3F80; in_valid = 1'b1;
    @(negedge clock);
    opA = 16'h4000; opB = 16'h3F00;
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_diff", 32'(diff), 32'h4000);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_diff", 32'(diff), 0);
    check("async_rst_flags", 32'({underflow, overflow, inexact, cout}), 0);
    check("async_rst_in_ready", 32'(in_ready), 1);
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) stale = 1'b1;
    end
    check("post_rst_no_stale", 32'(stale), 0);
    run_vec(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
